io_out_port: RTL and testbench

IO_OUT_PORT -- requirements
Module: io_out_port

---
 rtl/io_out_port.sv | 124 ++++++++++++
 tb/tb_io_out_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/io_out_port.sv
// io_out_port: CPU-write-snooping output port with an optional LED register and
// a small transmit FIFO drained through a valid/ready handshake.
// Latency: a TX write at edge N shows up on out_valid/out_data after edge N; there is no empty-FIFO bypass.
// Backpressure: out_ready=0 holds the head byte. A TX write while full with no pop is dropped and sets sticky overflow.
// Ports: clock, reset (synchronous, active-high), we/wr_addr/wr_data (CPU write),
//   led_out (LED value), out_data/out_valid/out_ready (FIFO head handshake),
//   space_avail (FIFO not full) and overflow (sticky, cleared by writing 1 in bit 0 to CLR_ADDR).
// Build option: define IO_OUT_PORT_LED_EN to build the LED register. Otherwise led_out is tied to 0.
module io_out_port #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_ADDR   = 4,
  parameter int TX_ADDR    = 5,
  parameter int CLR_ADDR   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  output logic [BUS_WIDTH-1:0]  led_out,
  output logic [BUS_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  space_avail,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] TX_A    = ADDR_WIDTH'(TX_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CLR_A   = ADDR_WIDTH'(CLR_ADDR);

  logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic tx_wr, full, push, pop, drop, clr;

  // The status outputs come only from registered state.
  assign out_valid   = (count_q != '0);
  assign space_avail = (count_q != DEPTH_C);
  assign overflow    = overflow_q;
  assign out_data    = mem_q[rd_ptr_q];

  always_comb begin
    tx_wr = we && (wr_addr == TX_A);
    full  = (count_q == DEPTH_C);
    pop   = out_valid && out_ready;
    // A pop in the same cycle frees one entry, so a write to a full FIFO is accepted.
    push  = tx_wr && (!full || pop);
    drop  = tx_wr && full && !pop;
    clr   = we && (wr_addr == CLR_A) && wr_data[0];

    // The depth is a power of two, so the pointers wrap naturally.
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // When a drop and a clear happen in the same cycle, the drop wins.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The storage array has no reset. Only the entries between the pointers are meaningful.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef IO_OUT_PORT_LED_EN
  localparam logic [ADDR_WIDTH-1:0] LED_A = ADDR_WIDTH'(LED_ADDR);
  logic [BUS_WIDTH-1:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (we && (wr_addr == LED_A)) begin
      led_d = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_out = led_q;
`else
  assign led_out = '0;
`endif

endmodule

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port.
// The expected behaviour comes from a queue-based model: a byte list, a sticky flag and an LED value.
// There are directed scenarios followed by a randomized run with occasional resets.
module tb_io_out_port;

  localparam int BW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int LED_A = 4;
  localparam int TX_A  = 5;
  localparam int CLR_A = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  logic [BW-1:0] led_out;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          space_avail;
  logic          overflow;

  io_out_port #(
    .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .LED_ADDR(LED_A), .TX_ADDR(TX_A), .CLR_ADDR(CLR_A)
  ) dut (
    .clock(clock), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .led_out(led_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .space_avail(space_avail), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [BW-1:0] mq[$];
  logic          m_ov;
  logic [BW-1:0] m_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the rules of one rising edge to the model, using the inputs currently driven.
  task automatic model_edge();
    bit popped, is_full, tx;
    if (reset) begin
      mq.delete();
      m_ov  = 1'b0;
      m_led = '0;
      return;
    end
    popped  = (mq.size() > 0) && out_ready;
    is_full = (mq.size() == DEPTH);
    tx      = we && (int'(wr_addr) == TX_A);
    if (popped) void'(mq.pop_front());
    if (tx && (!is_full || popped)) mq.push_back(wr_data);
    if (tx && is_full && !popped) m_ov = 1'b1;
    else if (we && int'(wr_addr) == CLR_A && wr_data[0]) m_ov = 1'b0;
`ifdef IO_OUT_PORT_LED_EN
    if (we && int'(wr_addr) == LED_A) m_led = wr_data;
`endif
  endtask

  // Advance one clock edge, then compare every output against the model.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    chk({tag, ":valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ":space"}, 32'(space_avail), 32'(mq.size() != DEPTH));
    chk({tag, ":ovf"}, 32'(overflow), 32'(m_ov));
    chk({tag, ":led"}, 32'(led_out), 32'(m_led));
    if (mq.size() != 0) chk({tag, ":data"}, 32'(out_data), 32'(mq[0]));
  endtask

  task automatic wr(input string tag, input int a, input int d, input logic rdy);
    we = 1'b1; wr_addr = AW'(a); wr_data = BW'(d); out_ready = rdy;
    cycle(tag);
    we = 1'b0; out_ready = 1'b0;
  endtask

  task automatic idle(input string tag, input logic rdy, input int n);
    we = 1'b0; out_ready = rdy;
    for (int i = 0; i < n; i++) cycle(tag);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle("reset"); reset = 1'b0;
  endtask

  initial begin
    we = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0; reset = 1'b1;
    mq.delete(); m_ov = 1'b0; m_led = '0;
    @(posedge clock); #1;
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_space", 32'(space_avail), 1);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_led", 32'(led_out), 0);

    // A single byte appears one edge after the write and holds while out_ready is low.
    wr("tx_a5", TX_A, 'hA5, 1'b0);
    chk("a5_valid", 32'(out_valid), 1);
    chk("a5_data", 32'(out_data), 'hA5);
    chk("a5_space", 32'(space_avail), 1);
    idle("a5_hold", 1'b0, 3);
    chk("a5_stable", 32'(out_data), 'hA5);
    idle("a5_pop", 1'b1, 1);
    chk("a5_empty", 32'(out_valid), 0);

    // Fill the FIFO, drop a fifth write, then drain in order.
    for (int i = 1; i <= 4; i++) wr("fill", TX_A, i, 1'b0);
    chk("full_space", 32'(space_avail), 0);
    wr("drop5", TX_A, 5, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(out_data), i);
      idle("drain", 1'b1, 1);
    end
    chk("drained", 32'(out_valid), 0);
    wr("clr", CLR_A, 1, 1'b0);
    chk("clr_ovf", 32'(overflow), 0);

    // A push to a full FIFO with a pop in the same cycle is accepted.
    for (int i = 1; i <= 4; i++) wr("fill2", TX_A, 'h20 + i, 1'b0);
    wr("push_pop_full", TX_A, 'h10, 1'b1);
    chk("pp_still_full", 32'(space_avail), 0);
    chk("pp_no_ovf", 32'(overflow), 0);
    idle("pp_drain", 1'b1, 3);
    chk("pp_last", 32'(out_data), 'h10);
    idle("pp_drain_last", 1'b1, 1);

    // The overflow flag stays set through further drops and a clear with bit 0 = 0, then clears.
    for (int i = 1; i <= 4; i++) wr("fill3", TX_A, i, 1'b0);
    wr("drop_a", TX_A, 'h99, 1'b0);
    wr("drop_b", TX_A, 'h98, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    wr("clr_bit0_zero", CLR_A, 'hFE, 1'b0);
    chk("ovf_hold", 32'(overflow), 1);
    wr("clr_iso", CLR_A, 1, 1'b0);
    chk("ovf_clr", 32'(overflow), 0);
    idle("drain3", 1'b1, 4);

    // Reset with bytes queued discards them. Reset also overrides a simultaneous TX write.
    wr("led3c", LED_A, 'h3C, 1'b0);
    for (int i = 1; i <= 3; i++) wr("q3", TX_A, 'h40 + i, 1'b0);
    reset = 1'b1; we = 1'b1; wr_addr = AW'(TX_A); wr_data = 'h55; out_ready = 1'b1;
    cycle("mid_reset");
    reset = 1'b0; we = 1'b0; out_ready = 1'b0;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_space", 32'(space_avail), 1);
    chk("mr_led", 32'(led_out), 0);
    wr("p77", TX_A, 'h77, 1'b0);
    chk("p77_first", 32'(out_data), 'h77);
    idle("p77_pop", 1'b1, 1);

    // LED writes take effect only when the LED register is built. Unmapped addresses change nothing.
    wr("led5a", LED_A, 'h5A, 1'b0);
`ifdef IO_OUT_PORT_LED_EN
    chk("led_5a", 32'(led_out), 'h5A);
`else
    chk("led_5a", 32'(led_out), 0);
`endif
    wr("addr7", 7, 'hFF, 1'b0);
    wr("addr0", 0, 'hFF, 1'b0);
    chk("addr7_valid", 32'(out_valid), 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      we        = $urandom_range(0, 3) != 0;
      wr_addr   = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wr_addr = AW'(TX_A);
      wr_data   = BW'($urandom);
      out_ready = $urandom_range(0, 2) == 0;
      cycle("rand");
    end
    reset = 1'b0; we = 1'b0; out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
